// File: rtl/rf_wb_sched_pkg.sv
// rf_wb_sched shared types and defaults
// Write-port scheduler: widths, FIFO entry, hazard helper

package rf_wb_sched_pkg;

    localparam int XLEN            = 32;
    localparam int RFIDX_WIDTH     = 5;
    localparam int RFREG_NUM       = 32;
    localparam int WB_FIFO_DEPTH   = 4;
    localparam int WB_STARVE_LIMIT = 3;

    typedef logic [RFIDX_WIDTH-1:0] rfidx_t;

    typedef struct packed {
        logic [31:0]     pc;
        logic [XLEN-1:0] wd;
        rfidx_t          wa;
    } wb_ent_t;

    // A register is pending unless it is x0 or is
    // being written from the FIFO head this cycle.
    function automatic logic pend(
        input logic [RFREG_NUM-1:0] busy,
        input logic                 pop,
        input rfidx_t               hwa,
        input rfidx_t               idx
    );
        return busy[idx] && (idx != '0) &&
               !(pop && (hwa == idx));
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: buffer for long-latency results
// Power-of-two depth, head read combinationally

module rf_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign head    = mem[rptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/rf_wb_sched.sv
// rf_wb_sched: regfile write-port arbiter
// and long-latency destination scoreboard

module rf_wb_sched
    import rf_wb_sched_pkg::*;
#(
    parameter int FIFO_DEPTH   = WB_FIFO_DEPTH,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   iss_valid,
    input  logic [RFIDX_WIDTH-1:0] iss_rd,
    output logic                   iss_ready,
    input  logic [RFIDX_WIDTH-1:0] ra1,
    input  logic [RFIDX_WIDTH-1:0] ra2,
    input  logic [RFIDX_WIDTH-1:0] rd_dec,
    output logic                   hz1,
    output logic                   hz2,
    output logic                   hzd,
    input  logic                   p_we,
    input  logic [RFIDX_WIDTH-1:0] p_wa,
    input  logic [XLEN-1:0]        p_wd,
    input  logic [31:0]            p_pc,
    input  logic                   l_valid,
    input  logic [RFIDX_WIDTH-1:0] l_wa,
    input  logic [XLEN-1:0]        l_wd,
    input  logic [31:0]            l_pc,
    output logic                   l_ready,
    output logic                   we3,
    output logic [RFIDX_WIDTH-1:0] wa3,
    output logic [XLEN-1:0]        wd3,
    output logic [31:0]            pc,
    output logic                   stall_wb
);

    localparam int EW = $bits(wb_ent_t);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    logic [RFREG_NUM-1:0] busy;
    logic [RFREG_NUM-1:0] busy_nxt;
    logic [SW-1:0]        starve_cnt;
    logic [SW-1:0]        starve_nxt;
    wb_ent_t              l_ent;
    wb_ent_t              head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pipe_sel;
    logic                 pop_sel;
    logic                 iss_fire;

    assign l_ent    = {l_pc, l_wd, l_wa};
    assign l_ready  = !full;
    assign push     = l_valid && l_ready;
    assign pipe_sel = p_we && (p_wa != '0);
    assign pop_sel  = !pipe_sel && !empty;

    assign iss_ready = !busy[iss_rd] || (iss_rd == '0);
    assign iss_fire  = iss_valid && iss_ready &&
                       (iss_rd != '0);

    assign hz1 = pend(busy, pop_sel, head.wa, ra1);
    assign hz2 = pend(busy, pop_sel, head.wa, ra2);
    assign hzd = pend(busy, pop_sel, head.wa, rd_dec);

    rf_wb_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   (l_ent),
        .pop   (pop_sel),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // Write port driven by the arbitration winner.
    always_comb begin
        we3 = 1'b0;
        wa3 = '0;
        wd3 = '0;
        pc  = '0;
        unique case (1'b1)
            pipe_sel: begin
                we3 = 1'b1;
                wa3 = p_wa;
                wd3 = p_wd;
                pc  = p_pc;
            end
            pop_sel: begin
                we3 = (head.wa != '0);
                wa3 = head.wa;
                wd3 = head.wd;
                pc  = head.pc;
            end
            default: begin
                we3 = 1'b0;
            end
        endcase
    end

    // Scoreboard: set on issue, clear on pop; x0 never busy.
    always_comb begin
        busy_nxt = busy;
        if (pop_sel) begin
            busy_nxt[head.wa] = 1'b0;
        end
        if (iss_fire) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Count cycles the FIFO head loses the port.
    always_comb begin
        starve_nxt = starve_cnt;
        if (empty || pop_sel) begin
            starve_nxt = '0;
        end else if (pipe_sel && starve_cnt != LIM) begin
            starve_nxt = starve_cnt + 1'b1;
        end
    end

    // Register scoreboard, starvation count and bubble request.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy       <= '0;
            starve_cnt <= '0;
            stall_wb   <= 1'b0;
        end else begin
            busy       <= busy_nxt;
            starve_cnt <= starve_nxt;
            if (pop_sel) begin
                stall_wb <= 1'b0;
            end else if (starve_nxt == LIM) begin
                stall_wb <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched: directed scoreboard bench
// Expected port writes queued at stimulus, checked by monitor

module tb_rf_wb_sched;
    import rf_wb_sched_pkg::*;

    logic            clk = 1'b0;
    logic            rstn;
    logic            iss_valid;
    rfidx_t          iss_rd;
    logic            iss_ready;
    rfidx_t          ra1, ra2, rd_dec;
    logic            hz1, hz2, hzd;
    logic            p_we;
    rfidx_t          p_wa;
    logic [XLEN-1:0] p_wd;
    logic [31:0]     p_pc;
    logic            l_valid;
    rfidx_t          l_wa;
    logic [XLEN-1:0] l_wd;
    logic [31:0]     l_pc;
    logic            l_ready;
    logic            we3;
    rfidx_t          wa3;
    logic [XLEN-1:0] wd3;
    logic [31:0]     pc;
    logic            stall_wb;

    typedef struct {
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] pc;
    } exp_t;

    exp_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic mon_en = 1'b0;

    rf_wb_sched dut (
        .clk       (clk),
        .rstn      (rstn),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd_dec    (rd_dec),
        .hz1       (hz1),
        .hz2       (hz2),
        .hzd       (hzd),
        .p_we      (p_we),
        .p_wa      (p_wa),
        .p_wd      (p_wd),
        .p_pc      (p_pc),
        .l_valid   (l_valid),
        .l_wa      (l_wa),
        .l_wd      (l_wd),
        .l_pc      (l_pc),
        .l_ready   (l_ready),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .pc        (pc),
        .stall_wb  (stall_wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    // Monitor: every regfile write must match the queue head.
    always @(negedge clk) begin
        if (mon_en && we3 === 1'b1) begin
            if (expq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL wb_unexpected: got wa3=%0d wd3=%0h expected no write",
                         wa3, wd3);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("wb_wa3", 32'(wa3), e.wa);
                chk("wb_wd3", wd3, e.wd);
                chk("wb_pc", pc, e.pc);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic exp_push(input int wa,
                            input logic [31:0] wd,
                            input logic [31:0] epc);
        exp_t e;
        e.wa = 32'(wa);
        e.wd = wd;
        e.pc = epc;
        expq.push_back(e);
    endtask

    task automatic pipe(input int wa,
                        input logic [31:0] wd,
                        input logic [31:0] ppc);
        p_we = 1'b1;
        p_wa = rfidx_t'(wa);
        p_wd = wd;
        p_pc = ppc;
        exp_push(wa, wd, ppc);
    endtask

    task automatic long_res(input int wa,
                            input logic [31:0] wd,
                            input logic [31:0] lpc);
        l_valid = 1'b1;
        l_wa    = rfidx_t'(wa);
        l_wd    = wd;
        l_pc    = lpc;
    endtask

    initial begin
        rstn = 1'b0;
        iss_valid = 1'b0; iss_rd = '0;
        ra1 = '0; ra2 = '0; rd_dec = '0;
        p_we = 1'b0; p_wa = '0; p_wd = '0; p_pc = '0;
        l_valid = 1'b0; l_wa = '0; l_wd = '0; l_pc = '0;

        // reset state
        nxt();
        nxt();
        mon_en = 1'b1;
        iss_rd = 5; ra1 = 5; ra2 = 6; rd_dec = 7;
        settle();
        chk("rst_l_ready", 32'(l_ready), 1);
        chk("rst_iss_ready", 32'(iss_ready), 1);
        chk("rst_we3", 32'(we3), 0);
        chk("rst_stall", 32'(stall_wb), 0);
        chk("rst_hz1", 32'(hz1), 0);
        chk("rst_hz2", 32'(hz2), 0);
        chk("rst_hzd", 32'(hzd), 0);
        nxt();
        rstn = 1'b1;

        // basic issue / result / pop
        iss_valid = 1'b1; iss_rd = 5; ra1 = 5;
        settle();
        chk("t1_iss_ready", 32'(iss_ready), 1);
        chk("t1_hz1_pre", 32'(hz1), 0);
        nxt();
        iss_valid = 1'b0;
        long_res(5, 32'h1234, 32'h80);
        exp_push(5, 32'h1234, 32'h80);
        settle();
        chk("t1_hz1_busy", 32'(hz1), 1);
        chk("t1_we3_empty", 32'(we3), 0);
        nxt();
        l_valid = 1'b0;
        settle();
        chk("t1_we3_pop", 32'(we3), 1);
        chk("t1_hz1_pop", 32'(hz1), 0);
        chk("t1_iss_ready_busy", 32'(iss_ready), 0);
        nxt();
        settle();
        chk("t1_iss_ready_clr", 32'(iss_ready), 1);
        chk("t1_hz1_clr", 32'(hz1), 0);
        chk("t1_we3_idle", 32'(we3), 0);

        // starvation and bubble
        nxt();
        iss_valid = 1'b1; iss_rd = 5;
        settle();
        nxt();
        iss_valid = 1'b0;
        long_res(5, 32'h5555, 32'h84);
        settle();
        nxt();
        l_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pipe(7, 32'h700 + 32'(i), 32'h100 + 32'(4 * i));
            settle();
            chk("t2_hz1_wait", 32'(hz1), 1);
            chk("t2_stall_pre", 32'(stall_wb), 0);
            nxt();
        end
        p_we = 1'b0;
        exp_push(5, 32'h5555, 32'h84);
        settle();
        chk("t2_stall_hi", 32'(stall_wb), 1);
        chk("t2_hz1_pop", 32'(hz1), 0);
        nxt();
        settle();
        chk("t2_stall_lo", 32'(stall_wb), 0);

        // fill / drain rounds with pointer wrap
        for (int r = 0; r < 10; r++) begin
            int n;
            n = (r % 2 == 0) ? 4 : 3;
            nxt();
            for (int i = 0; i < n; i++) begin
                pipe(7, 32'h1000 + 32'(r * 16 + i), 32'h400);
                long_res(10 + i, 32'h2000 + 32'(r * 16 + i),
                         32'h500 + 32'(4 * i));
                settle();
                chk("t3_l_ready", 32'(l_ready), 1);
                nxt();
            end
            if (n == 4) begin
                pipe(7, 32'h3000 + 32'(r), 32'h404);
                long_res(14, 32'hbad, 32'h5ff);
                settle();
                chk("t3_l_ready_full", 32'(l_ready), 0);
                nxt();
            end
            l_valid = 1'b0;
            p_we = 1'b0;
            for (int i = 0; i < n; i++) begin
                exp_push(10 + i, 32'h2000 + 32'(r * 16 + i),
                         32'h500 + 32'(4 * i));
                settle();
                if (i < n - 1) nxt();
            end
        end

        // long op to x0
        nxt();
        iss_valid = 1'b1; iss_rd = 0;
        settle();
        chk("t4_iss_ready", 32'(iss_ready), 1);
        nxt();
        iss_valid = 1'b0;
        long_res(0, 32'hdead, 32'h300);
        settle();
        nxt();
        l_valid = 1'b0;
        settle();
        chk("t4_pop_we3", 32'(we3), 0);
        chk("t4_pop_pc", pc, 32'h300);
        nxt();
        long_res(3, 32'h33, 32'h304);
        exp_push(3, 32'h33, 32'h304);
        settle();
        chk("t4_empty_we3", 32'(we3), 0);
        nxt();
        l_valid = 1'b0;
        settle();
        chk("t4_next_we3", 32'(we3), 1);

        // WAW hazard on x9
        nxt();
        iss_valid = 1'b1; iss_rd = 9;
        settle();
        nxt();
        iss_valid = 1'b0;
        long_res(9, 32'h99, 32'h900);
        exp_push(9, 32'h99, 32'h900);
        rd_dec = 9; iss_rd = 9;
        settle();
        chk("t5_hzd", 32'(hzd), 1);
        chk("t5_iss_ready", 32'(iss_ready), 0);
        nxt();
        l_valid = 1'b0;
        settle();
        chk("t5_hzd_pop", 32'(hzd), 0);
        chk("t5_iss_ready_pop", 32'(iss_ready), 0);
        nxt();
        settle();
        chk("t5_iss_ready_after", 32'(iss_ready), 1);
        chk("t5_hzd_after", 32'(hzd), 0);

        // reset mid-operation
        nxt();
        iss_valid = 1'b1; iss_rd = 11;
        settle();
        nxt();
        iss_rd = 12;
        settle();
        nxt();
        iss_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pipe(7, 32'h600 + 32'(i), 32'h600);
            long_res(11 + i, 32'h6100 + 32'(i), 32'h610);
            settle();
            nxt();
        end
        l_valid = 1'b0;
        pipe(7, 32'h610, 32'h610);
        settle();
        nxt();
        rstn = 1'b0;
        pipe(7, 32'h611, 32'h611);
        ra1 = 11; ra2 = 12; iss_rd = 11;
        settle();
        chk("t6_stall_pre", 32'(stall_wb), 1);
        chk("t6_hz1_pre", 32'(hz1), 1);
        chk("t6_hz2_pre", 32'(hz2), 1);
        nxt();
        rstn = 1'b1;
        p_we = 1'b0;
        settle();
        chk("t6_we3", 32'(we3), 0);
        chk("t6_l_ready", 32'(l_ready), 1);
        chk("t6_stall", 32'(stall_wb), 0);
        chk("t6_hz1", 32'(hz1), 0);
        chk("t6_hz2", 32'(hz2), 0);
        chk("t6_iss_ready", 32'(iss_ready), 1);
        nxt();
        settle();
        chk("t6_we3_hold", 32'(we3), 0);

        nxt();
        settle();
        chk("sb_drained", 32'(expq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
